// File: rtl/fetch_pkg.sv
// Shared encodings for the fetch controller: next-PC selects, FSM states and
// the cause-register field layout.
package fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CODE_W    = 5;
    localparam int unsigned PCS_W     = 3;
    localparam int unsigned CAUSE_LSB = 2;
    localparam int unsigned CAUSE_MSB = CAUSE_LSB + CODE_W - 1;

    localparam logic [PCS_W-1:0] PCS_SEQ    = 3'd0;
    localparam logic [PCS_W-1:0] PCS_EPC    = 3'd1;
    localparam logic [PCS_W-1:0] PCS_BRANCH = 3'd2;
    localparam logic [PCS_W-1:0] PCS_JUMP   = 3'd3;
    localparam logic [PCS_W-1:0] PCS_BASE   = 3'd4;
    localparam logic [PCS_W-1:0] PCS_VEC    = 3'd5;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_EXC  = 2'd2
    } state_e;

    // Places a cause code into its field of an otherwise-zero cause word.
    function automatic logic [XLEN-1:0] cause_word(input logic [CODE_W-1:0] code);
        cause_word = '0;
        cause_word[CAUSE_MSB:CAUSE_LSB] = code;
    endfunction

endpackage

// File: rtl/cp0_regs.sv
// Exception state registers: saved PC, cause code and interrupt enable.
module cp0_regs
    import fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              save_en,
    input  logic [XLEN-1:0]   save_epc,
    input  logic [CODE_W-1:0] save_code,
    input  logic              set_ie,
    input  logic              clr_ie,
    output logic [XLEN-1:0]   epc,
    output logic [XLEN-1:0]   cause,
    output logic              ie
);

    logic [XLEN-1:0]   epc_q,  epc_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              ie_q,   ie_d;

    always_comb begin
        epc_d  = epc_q;
        code_d = code_q;
        ie_d   = ie_q;
        if (save_en) begin
            epc_d  = save_epc;
            code_d = save_code;
        end
        if (set_ie) ie_d = 1'b1;
        if (clr_ie) ie_d = 1'b0;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            epc_q  <= '0;
            code_q <= '0;
            ie_q   <= 1'b0;
        end else begin
            epc_q  <= epc_d;
            code_q <= code_d;
            ie_q   <= ie_d;
        end
    end

    assign epc   = epc_q;
    assign cause = cause_word(code_q);
    assign ie    = ie_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC control: picks the PC mux source each cycle and sequences entry
// into the exception vector, saving EPC/cause on the way in.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0]   VECTOR_ADDR = 32'h0000_0008,
    parameter logic [CODE_W-1:0] IRQ_CODE    = 5'd0
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jr,
    input  logic              eret,
    input  logic              exc,
    input  logic [CODE_W-1:0] exc_code,
    input  logic              irq,
    input  logic [XLEN-1:0]   pc,
    output logic              pc_we,
    output logic [PCS_W-1:0]  pcsrc,
    output logic [XLEN-1:0]   vec,
    output logic [XLEN-1:0]   epc,
    output logic [XLEN-1:0]   cause,
    output logic              ie,
    output logic              flush
);

    state_e            state_q, state_d;
    logic              save_en;
    logic [CODE_W-1:0] save_code;
    logic              set_ie;
    logic              clr_ie;

    assign vec = VECTOR_ADDR;

    // Mux select and flush are needed in the same cycle, so they stay combinational.
    always_comb begin
        state_d   = state_q;
        pc_we     = 1'b0;
        pcsrc     = PCS_SEQ;
        flush     = 1'b0;
        save_en   = 1'b0;
        save_code = '0;
        set_ie    = 1'b0;
        clr_ie    = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    if (exc) begin
                        save_en   = 1'b1;
                        save_code = exc_code;
                        state_d   = ST_EXC;
                    end else if (irq && ie) begin
                        save_en   = 1'b1;
                        save_code = IRQ_CODE;
                        state_d   = ST_EXC;
                    end else begin
                        pc_we = 1'b1;
                        if (eret) begin
                            pcsrc  = PCS_EPC;
                            set_ie = 1'b1;
                        end else if (jr) begin
                            pcsrc = PCS_BASE;
                        end else if (jump) begin
                            pcsrc = PCS_JUMP;
                        end else if (branch_taken) begin
                            pcsrc = PCS_BRANCH;
                        end
                    end
                end
            end
            ST_EXC: begin
                pcsrc   = PCS_VEC;
                pc_we   = 1'b1;
                flush   = 1'b1;
                clr_ie  = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) state_q <= ST_BOOT;
        else       state_q <= state_d;
    end

    cp0_regs u_cp0 (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .save_en   (save_en),
        .save_epc  (pc),
        .save_code (save_code),
        .set_ie    (set_ie),
        .clr_ie    (clr_ie),
        .epc       (epc),
        .cause     (cause),
        .ie        (ie)
    );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model.
module tb_fetch_ctrl;

    localparam logic [31:0] TB_VEC = 32'h0000_0008;
    localparam logic [4:0]  TB_IRQ = 5'd0;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        stall, branch_taken, jump, jr, eret, exc, irq;
    logic [4:0]  exc_code;
    logic [31:0] pc;
    logic        pc_we, ie, flush;
    logic [2:0]  pcsrc;
    logic [31:0] vec, epc, cause;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a boot cycle flag, a pending vector-entry flag and the saved state.
    bit          m_boot = 1'b1, m_exc = 1'b0, m_ie = 1'b0;
    logic [31:0] m_epc  = '0;
    logic [4:0]  m_code = '0;
    bit          n_boot = 1'b1, n_exc = 1'b0, n_ie = 1'b0;
    logic [31:0] n_epc  = '0;
    logic [4:0]  n_code = '0;

    fetch_ctrl #(.VECTOR_ADDR(TB_VEC), .IRQ_CODE(TB_IRQ)) dut (
        .Clk          (Clk),
        .Clrn         (Clrn),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .eret         (eret),
        .exc          (exc),
        .exc_code     (exc_code),
        .irq          (irq),
        .pc           (pc),
        .pc_we        (pc_we),
        .pcsrc        (pcsrc),
        .vec          (vec),
        .epc          (epc),
        .cause        (cause),
        .ie           (ie),
        .flush        (flush)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_exc = 1'b0; m_ie = 1'b0; m_epc = '0; m_code = '0;
        n_boot = 1'b1; n_exc = 1'b0; n_ie = 1'b0; n_epc = '0; n_code = '0;
    endtask

    always @(negedge Clrn) model_reset();

    always @(posedge Clk) begin
        if (Clrn) begin
            m_boot = n_boot; m_exc = n_exc; m_ie = n_ie; m_epc = n_epc; m_code = n_code;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge Clk) begin
        logic [2:0] exp_src;
        if (!Clrn) begin
            model_reset();
            chk("rst_pc_we", 32'(pc_we), 32'd0);
            chk("rst_pcsrc", 32'(pcsrc), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
            chk("rst_epc",   epc,        32'd0);
            chk("rst_cause", cause,      32'd0);
            chk("rst_ie",    32'(ie),    32'd0);
        end else begin
            n_boot = m_boot; n_exc = m_exc; n_ie = m_ie; n_epc = m_epc; n_code = m_code;
            chk("vec",   vec,               TB_VEC);
            chk("epc",   epc,               m_epc);
            chk("cause", cause,             32'(m_code) * 32'd4);
            chk("ie",    32'(ie),           32'(m_ie));
            if (m_boot) begin
                chk("boot_pc_we", 32'(pc_we), 32'd0);
                chk("boot_pcsrc", 32'(pcsrc), 32'd0);
                chk("boot_flush", 32'(flush), 32'd0);
                n_boot = 1'b0;
            end else if (m_exc) begin
                chk("exc_pc_we", 32'(pc_we), 32'd1);
                chk("exc_pcsrc", 32'(pcsrc), 32'd5);
                chk("exc_flush", 32'(flush), 32'd1);
                n_exc = 1'b0;
                n_ie  = 1'b0;
            end else begin
                chk("run_flush", 32'(flush), 32'd0);
                if (stall) begin
                    chk("stall_pc_we", 32'(pc_we), 32'd0);
                end else if (exc || (irq && m_ie)) begin
                    chk("entry_pc_we", 32'(pc_we), 32'd0);
                    n_epc  = pc;
                    n_code = exc ? exc_code : TB_IRQ;
                    n_exc  = 1'b1;
                end else begin
                    exp_src = eret ? 3'd1 : jr ? 3'd4 : jump ? 3'd3 : branch_taken ? 3'd2 : 3'd0;
                    chk("run_pc_we", 32'(pc_we), 32'd1);
                    chk("run_pcsrc", 32'(pcsrc), 32'(exp_src));
                    if (eret) n_ie = 1'b1;
                end
            end
        end
    end

    task automatic clr();
        stall = 0; branch_taken = 0; jump = 0; jr = 0; eret = 0;
        exc = 0; irq = 0; exc_code = '0; pc = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Clrn = 1'b0;
        clr();
        #12;
        chk("lit_rst_pc_we", 32'(pc_we), 32'd0);
        chk("lit_rst_ie",    32'(ie),    32'd0);
        #5 Clrn = 1'b1;
        @(negedge Clk);
        chk("lit_boot_pc_we", 32'(pc_we), 32'd0);
        tick(); clr();
        @(negedge Clk);
        chk("lit_seq_pc_we", 32'(pc_we), 32'd1);
        chk("lit_seq_pcsrc", 32'(pcsrc), 32'd0);

        // Redirect priority.
        tick(); clr(); jr = 1; jump = 1; branch_taken = 1;
        @(negedge Clk);
        chk("lit_jr_pri", 32'(pcsrc), 32'd4);
        tick(); clr(); branch_taken = 1;
        @(negedge Clk);
        chk("lit_branch", 32'(pcsrc), 32'd2);

        // Synchronous exception entry.
        tick(); clr(); pc = 32'h40; exc = 1; exc_code = 5'd12;
        @(negedge Clk);
        chk("lit_exc_pc_we", 32'(pc_we), 32'd0);
        tick(); clr();
        @(negedge Clk);
        chk("lit_vec_pcsrc", 32'(pcsrc), 32'd5);
        chk("lit_vec_flush", 32'(flush), 32'd1);
        chk("lit_vec",       vec,        32'h8);
        tick(); clr();
        @(negedge Clk);
        chk("lit_epc",   epc,     32'h40);
        chk("lit_cause", cause,   32'h30);
        chk("lit_ie0",   32'(ie), 32'd0);

        // Masked interrupt, then eret enables it and it is taken.
        tick(); clr(); irq = 1; pc = 32'h100;
        @(negedge Clk);
        chk("lit_irq_masked", 32'(pc_we), 32'd1);
        tick(); clr(); irq = 1; eret = 1; pc = 32'h100;
        @(negedge Clk);
        chk("lit_eret_pcsrc", 32'(pcsrc), 32'd1);
        tick(); clr(); irq = 1; pc = 32'h100;
        @(negedge Clk);
        chk("lit_eret_ie",   32'(ie),    32'd1);
        chk("lit_irq_entry", 32'(pc_we), 32'd0);
        tick(); clr();
        tick(); clr();
        @(negedge Clk);
        chk("lit_irq_cause", cause, 32'h0);
        chk("lit_irq_epc",   epc,   32'h100);

        // Stall holds off an exception until it drops.
        tick(); clr(); stall = 1; exc = 1; exc_code = 5'd3; pc = 32'h200;
        @(negedge Clk);
        chk("lit_stall_pc_we", 32'(pc_we), 32'd0);
        tick();
        @(negedge Clk);
        chk("lit_stall_epc", epc, 32'h100);
        tick(); stall = 0;
        tick(); clr();
        @(negedge Clk);
        chk("lit_stall_flush", 32'(flush), 32'd1);
        tick(); clr();
        @(negedge Clk);
        chk("lit_stall_epc2",  epc,   32'h200);
        chk("lit_stall_cause", cause, 32'hC);

        // exc beats eret; reset during the vector cycle wipes everything.
        tick(); clr(); eret = 1;
        tick(); clr(); exc = 1; eret = 1; exc_code = 5'd7; pc = 32'h300;
        @(negedge Clk);
        chk("lit_exc_eret_pc_we", 32'(pc_we), 32'd0);
        tick(); clr();
        chk("lit_exc_eret_ie", 32'(ie), 32'd1);
        chk("lit_exc_epc",     epc,     32'h300);
        Clrn = 1'b0;
        #1;
        chk("lit_arst_epc",   epc,        32'd0);
        chk("lit_arst_cause", cause,      32'd0);
        chk("lit_arst_ie",    32'(ie),    32'd0);
        chk("lit_arst_flush", 32'(flush), 32'd0);
        chk("lit_arst_pc_we", 32'(pc_we), 32'd0);
        Clrn = 1'b1;
        @(negedge Clk);
        chk("lit_arst_boot", 32'(pc_we), 32'd0);

        // Randomized traffic, with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            tick();
            stall        = ($urandom_range(0, 99) < 20);
            exc          = ($urandom_range(0, 99) < 10);
            irq          = ($urandom_range(0, 99) < 30);
            eret         = ($urandom_range(0, 99) < 15);
            jr           = ($urandom_range(0, 99) < 25);
            jump         = ($urandom_range(0, 99) < 25);
            branch_taken = ($urandom_range(0, 99) < 25);
            exc_code     = 5'($urandom_range(0, 31));
            pc           = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 249) == 0) begin
                Clrn = 1'b0;
                #2;
                Clrn = 1'b1;
            end
        end
        tick(); clr();
        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter VECTOR_ADDR, default 32'h0000_0008: exception/interrupt handler entry address.
REQ-002 SHALL have parameter IRQ_CODE, default 5'd0: cause code recorded for an external interrupt.
REQ-003 SHALL have port Clk  input  1  single rising-edge clock.
REQ-004 SHALL have port Clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  datapath hold; PC must not advance.
REQ-006 SHALL have ports branch_taken, jump, jr, eret  input  1 each  decoded redirect requests from the current instruction.
REQ-007 SHALL have port exc  input  1  synchronous exception on the current instruction.
REQ-008 SHALL have port exc_code  input  5  exception cause code.
REQ-009 SHALL have port irq  input  1  level-sensitive external interrupt.
REQ-010 SHALL have port pc  input  32  current PC register value.
REQ-011 SHALL have port pc_we  output  1  PC register load enable.
REQ-012 SHALL have port pcsrc  output  3  next-PC mux select: 0 PC+4, 1 EPC, 2 BRANCH, 3 JUMP, 4 BASE (jr), 5 VECTOR.
REQ-013 SHALL have port vec  output  32  constant VECTOR_ADDR, driven to the next-PC mux.
REQ-014 SHALL have ports epc  output  32  and cause  output  32  (cause[6:2] = code, all other bits 0).
REQ-015 SHALL have port ie  output  1  interrupt enable.
REQ-016 SHALL have port flush  output  1  squash the instruction currently fetched.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, EXC.
REQ-018 BOOT: pc_we=0, pcsrc=0; SHALL go to RUN on the next edge.
REQ-019 RUN, stall=1: pc_we=0; all redirect inputs, exc and irq SHALL be ignored that cycle; no register updates.
REQ-020 RUN, stall=0: priority exc > (irq & ie) > eret > jr > jump > branch_taken > sequential.
REQ-021 exc or (irq & ie) taken in RUN: pc_we=0 that cycle; at the edge epc<=pc, cause code<=exc_code (exc) or IRQ_CODE (irq), state->EXC.
REQ-022 EXC: pcsrc=5, pc_we=1, flush=1; at the edge ie<=0, state->RUN; all inputs SHALL be ignored.
REQ-023 eret: pcsrc=1, pc_we=1; ie<=1 at the edge.
REQ-024 jr/jump/branch_taken: pcsrc=4/3/2 respectively, pc_we=1; otherwise pcsrc=0, pc_we=1.
REQ-025 pcsrc, pc_we and flush SHALL be combinational from state and inputs (same-cycle mux select); epc, cause, ie and state SHALL be registered.
REQ-026 exc SHALL be taken regardless of ie, overwriting epc and cause.
REQ-027 irq with ie=0 SHALL have no effect; irq is not latched and must remain asserted until taken.
REQ-028 exc and eret in the same cycle: exc wins; ie is unchanged until EXC clears it.

Reset
REQ-029 Clrn low SHALL immediately force state=BOOT, epc=0, cause=0, ie=0, independent of Clk.
REQ-030 During reset: pc_we=0, pcsrc=0, flush=0; reset asserted mid-EXC SHALL abandon the entry with no partial update.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the pcsrc encodings (PCS_SEQ..PCS_VEC), the FSM state encoding, and the cause-field bit positions.
REQ-032 epc, cause and ie SHALL live in one sub-module, cp0_regs, written only by fetch_ctrl.

Verification
REQ-033 Reset released, no requests -> one BOOT cycle with pc_we=0, then pcsrc=0, pc_we=1 every cycle.
REQ-034 jr=jump=branch_taken=1, stall=0 -> pcsrc=4; with only branch_taken=1 -> pcsrc=2.
REQ-035 pc=32'h40, exc=1, exc_code=5'd12 -> that cycle pc_we=0; next cycle pcsrc=5, flush=1, vec=32'h8; afterwards epc=32'h40, cause=32'h30, ie=0.
REQ-036 ie=0, irq=1 -> no entry; eret -> pcsrc=1, ie=1 next cycle; irq still high -> entry with cause=0.
REQ-037 stall=1 with exc=1 -> pc_we=0, epc unchanged; stall drops with exc still high -> entry proceeds.
REQ-038 Clrn pulsed low during EXC -> epc=0, cause=0, ie=0, state BOOT immediately.
